final_bits_streamer: RTL and testbench
======================================

# final_bits_streamer

Sequential, parametrised end-of-frame flush unit for the AV1 arithmetic encoder, run once per tile after the last symbol. It accepts the final `low`/`cnt` pair and computes the terminating value e = ((low + M) & ~M) | (M + 1), with M = 2^14−1. It then streams 1..MAX_WORDS pre-carry words over a valid/ready handshake, one word per cycle. Each word carries its own carry bit so the downstream carry-propagation stage can resolve it.

## Interface
- `LOW_WIDTH`, 24: width of the encoder `low` register.
- `D_SIZE`, 5: width of the signed `cnt` input.
- `WORD_BITS`, 8: payload bits per output word; each output word is WORD_BITS+1 wide.
- `MAX_WORDS`, 3: maximum words per flush; it equals ceil((LOW_WIDTH−14)/WORD_BITS)+1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  flush request; `in_cnt`/`in_low` are valid.
- `in_ready`  out  1  high only in IDLE.
- `in_cnt`  in  D_SIZE  signed two's-complement cnt; legal range −9..LOW_WIDTH−17.
- `in_low`  in  LOW_WIDTH  final low.
- `out_valid`  out  1  `out_word` is valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_word`  out  WORD_BITS+1  pre-carry word; the MSB is the carry into the previous byte.
- `out_last`  out  1  marks the final word of this flush.
- `done`  out  1  one-cycle pulse when the flush completes.
- `err`  out  1  one-cycle pulse, coincident with `done`, when `in_cnt` was out of range.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - EMIT: `out_valid`=1.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- Accept in IDLE (`in_valid` & `in_ready`). Latch the following:
  - e: LOW_WIDTH+1 bits, including the carry out of low+M.
  - c = in_cnt, sign-extended to D_SIZE+1.
  - s = in_cnt + 10, signed D_SIZE+1.
  - n = 2^(c+LOW_WIDTH−WORD_BITS) − 1, LOW_WIDTH+1 bits.
- State after accept:
  - `in_cnt` out of range: go to DONE with `err`; no words emitted.
  - Otherwise: go to EMIT. s > 0 is guaranteed by the legal range.
- Word in EMIT: `out_word` = (e >> (c + LOW_WIDTH − WORD_BITS)) truncated to WORD_BITS+1 bits.
- `out_last`: 1 when s − WORD_BITS ≤ 0.
- On each output handshake:
  - e ← e & n;  s ← s − WORD_BITS;  c ← c − WORD_BITS;  n ← n >> WORD_BITS.
  - If `out_last` was 1, go to DONE.
- Word count per flush is ceil((cnt+10)/WORD_BITS); it never exceeds MAX_WORDS.
- Holding rule: `out_word` and `out_last` stay stable while `out_valid` is high and `out_ready` is low.
- `in_valid` in EMIT or DONE is ignored (`in_ready`=0). The request is not lost; the upstream holds it.

## Timing
- Reset values: state IDLE; `in_ready`=1; `out_valid`, `out_last`, `done`, `err`=0; `out_word`=0; internal e, c, s and n cleared.
- The first word is valid the cycle after accept.
- With `out_ready` held high, one word per cycle. The `done` pulse occurs the cycle after the last handshake, and IDLE follows one cycle after that.
- Total accept-to-IDLE time is words+2 cycles; the next accept is possible in that cycle.
- Reset asserted mid-flush aborts immediately: no `done` pulse, and partial words are not replayed.
- `out_ready` low stalls in EMIT indefinitely with no state change.
- All arithmetic is unsigned LOW_WIDTH+1 bits, except c and s, which are signed. The shift amount c+LOW_WIDTH−WORD_BITS is always ≥ 7 for legal cnt.

## Structure
- Shared package `final_bits_pkg`:
  - state enum (IDLE, EMIT, DONE);
  - constants M_MASK = 2^14−1 and CNT_MIN = −9;
  - function computing e from low.
- One sub-module is natural: `final_bits_word_shifter`. It is combinational and performs the barrel shift plus truncation for `out_word`. The FSM, counters and registers stay in the top level.

## Test plan
- low=0x000000, cnt=−9 → one word 0x080 with `out_last`=1; `done` the next cycle; `err`=0.
- low=0x123456, cnt=0 → words 0x012, then 0x040 (`out_last` on the second).
- low=0xFFFFFF, cnt=0 → words 0x100 (carry bit set), then 0x040.
- low=0, cnt=7 → three words 0x000, 0x000, 0x080.
  - Repeat with `out_ready` toggling randomly: same words, `out_word` stable while stalled.
- cnt=8 (out of range) → no `out_valid`; `done` and `err` pulse together the cycle after accept.
- Reset pulled low after the first word of the cnt=7 case → all outputs at reset values immediately. A new flush after reset release produces the correct full sequence.

Source files
------------

// File: rtl/final_bits_pkg.sv
// final_bits_pkg
// Shared definitions for the AV1 end-of-frame flush unit:
//   state_t  - flush FSM states
//   M_MASK   - low-bit mask (2^14-1) used to round the final low
//   CNT_MIN  - smallest legal cnt value
//   calc_e   - terminating value e = ((low + M) & ~M) | (M + 1), evaluated
//              on a wide word so callers can truncate to their own width
//              while keeping the carry out of low + M.
package final_bits_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

    localparam int          M_BITS  = 14;
    localparam logic [63:0] M_MASK  = (64'd1 << M_BITS) - 64'd1;
    localparam int          CNT_MIN = -9;

    // Caller passes low zero-extended to 64 bits; bit (LOW_WIDTH) of the
    // result is the carry out of low + M.
    function automatic logic [64:0] calc_e(input logic [63:0] low);
        logic [64:0] sum;
        sum = {1'b0, low} + {1'b0, M_MASK};
        return (sum & ~{1'b0, M_MASK}) | {1'b0, M_MASK + 64'd1};
    endfunction

endpackage

// File: rtl/final_bits_word_shifter.sv
// final_bits_word_shifter
// Combinational barrel shift that extracts one pre-carry output word:
//   word = (e >> (c + LOW_WIDTH - WORD_BITS)) truncated to WORD_BITS+1 bits.
// Ports:
//   e    in  LOW_WIDTH+1   remaining terminating value (with carry bit)
//   c    in  D_SIZE+1      signed running cnt
//   word out WORD_BITS+1   pre-carry word, MSB = carry into previous byte
import final_bits_pkg::*;

module final_bits_word_shifter #(
    parameter int LOW_WIDTH = 24,
    parameter int D_SIZE    = 5,
    parameter int WORD_BITS = 8
) (
    input  logic [LOW_WIDTH:0]        e,
    input  logic signed [D_SIZE:0]    c,
    output logic [WORD_BITS:0]        word
);

    int sh;

    always_comb begin
        sh   = int'(c) + LOW_WIDTH - WORD_BITS;
        word = '0;
        // A negative shift only appears after the last word has been
        // consumed; the word is not presented then, so emit zero.
        if (sh >= 0) begin
            word = (WORD_BITS+1)'(e >> sh);
        end
    end

endmodule

// File: rtl/final_bits_streamer.sv
// final_bits_streamer
// End-of-frame flush for the AV1 arithmetic encoder. Accepts the final
// low/cnt pair, forms the terminating value e and streams 1..MAX_WORDS
// pre-carry words (WORD_BITS payload + carry MSB) over valid/ready.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   in_valid   in   flush request
//   in_ready   out  high only in IDLE
//   in_cnt     in   D_SIZE signed cnt, legal -9..LOW_WIDTH-17
//   in_low     in   LOW_WIDTH final low
//   out_valid  out  out_word valid
//   out_ready  in   downstream accepts word
//   out_word   out  WORD_BITS+1 pre-carry word
//   out_last   out  final word of this flush
//   done       out  one-cycle pulse at flush completion
//   err        out  one-cycle pulse with done when in_cnt was out of range
import final_bits_pkg::*;

module final_bits_streamer #(
    parameter int LOW_WIDTH = 24,
    parameter int D_SIZE    = 5,
    parameter int WORD_BITS = 8,
    parameter int MAX_WORDS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [D_SIZE-1:0]     in_cnt,
    input  logic [LOW_WIDTH-1:0]  in_low,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_BITS:0]    out_word,
    output logic                  out_last,
    output logic                  done,
    output logic                  err
);

    // Word count is bounded by the cnt range; catch a mismatched override.
    if (MAX_WORDS != (LOW_WIDTH - 14 + WORD_BITS - 1) / WORD_BITS + 1) begin : g_bad_max_words
        $error("MAX_WORDS inconsistent with LOW_WIDTH/WORD_BITS");
    end

    localparam logic signed [D_SIZE:0] WB_S  = (D_SIZE+1)'(WORD_BITS);
    localparam logic signed [D_SIZE:0] TEN_S = (D_SIZE+1)'(10);
    localparam logic [LOW_WIDTH:0]     ONE   = (LOW_WIDTH+1)'(1);

    state_t                   state;
    logic [LOW_WIDTH:0]       e;
    logic signed [D_SIZE:0]   c;
    logic signed [D_SIZE:0]   s;
    logic [LOW_WIDTH:0]       n;

    // Values captured on accept
    logic signed [D_SIZE-1:0] cnt_s;
    logic signed [D_SIZE:0]   c_init;
    logic signed [D_SIZE:0]   s_init;
    logic [LOW_WIDTH:0]       e_init;
    logic [LOW_WIDTH:0]       n_init;
    int                       sh_init;
    logic                     cnt_ok;

    logic [WORD_BITS:0]       shift_word;
    logic                     last_word;

    always_comb begin
        cnt_s   = $signed(in_cnt);
        c_init  = {cnt_s[D_SIZE-1], cnt_s};
        s_init  = c_init + TEN_S;
        e_init  = (LOW_WIDTH+1)'(calc_e(64'(in_low)));
        sh_init = int'(c_init) + LOW_WIDTH - WORD_BITS;
        // n keeps every bit of e below the current word
        n_init  = (ONE << sh_init) - ONE;
        cnt_ok  = (int'(cnt_s) >= CNT_MIN) && (int'(cnt_s) <= LOW_WIDTH - 17);
    end

    // s counts the remaining significant bits; the word is last once
    // no more than WORD_BITS of them remain.
    assign last_word = (int'(s) <= WORD_BITS);

    final_bits_word_shifter #(
        .LOW_WIDTH (LOW_WIDTH),
        .D_SIZE    (D_SIZE),
        .WORD_BITS (WORD_BITS)
    ) u_shifter (
        .e    (e),
        .c    (c),
        .word (shift_word)
    );

    // Word/last derive from registers that only change on a handshake,
    // so they hold steady across an out_ready stall.
    assign out_word = out_valid ? shift_word : '0;
    assign out_last = out_valid & last_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            e         <= '0;
            c         <= '0;
            s         <= '0;
            n         <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        e        <= e_init;
                        c        <= c_init;
                        s        <= s_init;
                        n        <= n_init;
                        in_ready <= 1'b0;
                        if (!cnt_ok) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= EMIT;
                            out_valid <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        e <= e & n;
                        s <= s - WB_S;
                        c <= c - WB_S;
                        n <= n >> WORD_BITS;
                        if (last_word) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_final_bits_streamer.sv
// tb_final_bits_streamer
// Directed bench for final_bits_streamer: hand-computed word sequences,
// stall handling, out-of-range cnt and mid-flush reset.
module tb_final_bits_streamer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_cnt;
    logic [23:0] in_low;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_word;
    logic        out_last;
    logic        done;
    logic        err;

    int n_checks;
    int n_errors;

    final_bits_streamer #(
        .LOW_WIDTH (24),
        .D_SIZE    (5),
        .WORD_BITS (8),
        .MAX_WORDS (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cnt    (in_cnt),
        .in_low    (in_low),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request and return at posedge+1 of the accepting edge.
    task automatic start(input logic [4:0] cnt, input logic [23:0] low);
        int guard;
        guard    = 0;
        in_cnt   = cnt;
        in_low   = low;
        in_valid = 1'b1;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Consume nw words, checking each every cycle it is presented, then
    // the done pulse and the return to IDLE.
    task automatic run_words(input int nw, input logic [8:0] w0, input logic [8:0] w1,
                             input logic [8:0] w2, input bit rnd);
        logic [8:0] exp_w [3];
        int         guard;
        bit         took;
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2;
        for (int i = 0; i < nw; i++) begin
            guard = 0;
            took  = 1'b0;
            while (!took) begin
                out_ready = rnd ? ((guard >= 4) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
                check("out_valid", 32'(out_valid), 32'd1);
                check("out_word",  32'(out_word),  32'(exp_w[i]));
                check("out_last",  32'(out_last),  32'(i == nw - 1));
                check("in_ready_busy", 32'(in_ready), 32'd0);
                took = out_ready;
                @(posedge clk); #1;
                guard++;
                if (guard > 20) begin
                    check("word_timeout", 32'd0, 32'd1);
                    took = 1'b1;
                end
            end
        end
        out_ready = 1'b0;
        check("done_pulse", 32'(done),      32'd1);
        check("err_clear",  32'(err),       32'd0);
        check("valid_off",  32'(out_valid), 32'd0);
        check("ready_done", 32'(in_ready),  32'd0);
        @(posedge clk); #1;
        check("done_end",   32'(done),      32'd0);
        check("idle_ready", 32'(in_ready),  32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_cnt    = '0;
        in_low    = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word",  32'(out_word),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // low=0, cnt=-9: e=0x4000, shift 7 -> single word 0x080
        start(5'h17, 24'h000000);
        run_words(1, 9'h080, 9'h000, 9'h000, 1'b0);

        // low=0x123456, cnt=0: e=0x124000 -> 0x012, 0x040
        start(5'h00, 24'h123456);
        run_words(2, 9'h012, 9'h040, 9'h000, 1'b0);

        // low=0xFFFFFF, cnt=0: e=0x1004000 -> carry word 0x100, then 0x040
        start(5'h00, 24'hFFFFFF);
        run_words(2, 9'h100, 9'h040, 9'h000, 1'b0);

        // low=0, cnt=7: three words
        start(5'h07, 24'h000000);
        run_words(3, 9'h000, 9'h000, 9'h080, 1'b0);

        // Same cases with random out_ready stalls
        start(5'h07, 24'h000000);
        run_words(3, 9'h000, 9'h000, 9'h080, 1'b1);
        start(5'h00, 24'h123456);
        run_words(2, 9'h012, 9'h040, 9'h000, 1'b1);

        // cnt=8 out of range: no words, done+err the cycle after accept
        out_ready = 1'b1;
        start(5'h08, 24'h000000);
        check("err_valid",    32'(out_valid), 32'd0);
        check("err_done",     32'(done),      32'd1);
        check("err_pulse",    32'(err),       32'd1);
        @(posedge clk); #1;
        check("err_done_end", 32'(done),      32'd0);
        check("err_end",      32'(err),       32'd0);
        check("err_idle",     32'(in_ready),  32'd1);
        check("err_no_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Mid-flush reset after the first word of the cnt=7 case
        start(5'h07, 24'h000000);
        out_ready = 1'b1;
        check("mr_word0", 32'(out_word), 32'h000);
        @(posedge clk); #1;
        check("mr_valid_before", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        out_ready = 1'b0;
        check("mr_in_ready",  32'(in_ready),  32'd1);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_word",  32'(out_word),  32'd0);
        check("mr_out_last",  32'(out_last),  32'd0);
        check("mr_done",      32'(done),      32'd0);
        check("mr_err",       32'(err),       32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("mr_idle_after", 32'(out_valid), 32'd0);
        start(5'h07, 24'h000000);
        run_words(3, 9'h000, 9'h000, 9'h080, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
